axi_burst_splitter: RTL and testbench

Converts a byte-granular transfer request (start address, byte count, ID, direction) into a legal sequence of AXI4 address-channel bursts. Each burst is at most MAX_BURST_LEN beats and never crosses a 4 KB boundary. Optionally, a cache line fill is issued as a single critical-word-first WRAP burst. Sits between the cache miss/writeback controller and the AXI4 master AR/AW channel, and generalises the package-level burst-length calculator into a parametrised, multi-burst sequencer.

---
 rtl/axi_burst_splitter.sv | 200 ++++++++++++++++++++
 tb/tb_axi_burst_splitter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_splitter.sv
// Splits a byte-granular transfer request into AXI4 AR/AW bursts, each capped at MAX_BURST_LEN beats and 4 KB safe.
// Optional CACHE_WRAP_BURST_EN: issues an eligible cache line fill as a single critical-word-first WRAP burst.
module axi_burst_splitter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned MAX_BURST_LEN  = 16,
  parameter int unsigned BYTE_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [BYTE_CNT_WIDTH-1:0] req_bytes,
  input  logic [ID_WIDTH-1:0]       req_id,
  input  logic                      req_write,
  input  logic                      req_wrap,
  output logic                      ax_valid,
  input  logic                      ax_ready,
  output logic [ADDR_WIDTH-1:0]     ax_addr,
  output logic [7:0]                ax_len,
  output logic [2:0]                ax_size,
  output logic [1:0]                ax_burst,
  output logic [ID_WIDTH-1:0]       ax_id,
  output logic                      ax_write,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SHIFT = $clog2(BYTES);
  localparam int unsigned RW    = BYTE_CNT_WIDTH + 1;
  localparam int unsigned AW1   = ADDR_WIDTH + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

  logic [1:0]            state_q, state_n;
  logic [ADDR_WIDTH-1:0] cur_q, cur_n;
  logic [RW-1:0]         rem_q, rem_n;

  logic                  req_ready_n, ax_valid_n, busy_n, done_n, ax_write_n;
  logic [ADDR_WIDTH-1:0] ax_addr_n;
  logic [7:0]            ax_len_n;
  logic [1:0]            ax_burst_n;
  logic [ID_WIDTH-1:0]   ax_id_n;

  logic [AW1-1:0]        end_addr, total_beats;
  logic [ADDR_WIDTH-1:0] aligned, cur_adv;
  logic [8:0]            beats, issued;
  logic [RW-1:0]         rem_left;

  assign ax_size = 3'(SHIFT);

  // Beats that fit: bounded by what is left, the burst cap and the distance to the next 4 KB page.
  function automatic logic [8:0] burst_beats(input logic [11:0] off, input logic [RW-1:0] rem);
    logic [12:0] room;
    logic [31:0] lim;
    room = (13'd4096 - {1'b0, off}) >> SHIFT;
    lim  = 32'(MAX_BURST_LEN);
    if (32'(room) < lim) lim = 32'(room);
    if (32'(rem) < lim) lim = 32'(rem);
    return 9'(lim);
  endfunction

`ifdef CACHE_WRAP_BURST_EN
  // A line fill qualifies when it is exactly 2/4/8/16 beats, fits one burst and fits in a page.
  function automatic logic wrap_ok(input logic [BYTE_CNT_WIDTH-1:0] nb);
    logic ok;
    ok = 1'b0;
    for (int unsigned k = 2; k <= 16; k = k * 2) begin
      if (32'(nb) == k * BYTES && k <= MAX_BURST_LEN && k * BYTES <= 4096) ok = 1'b1;
    end
    return ok;
  endfunction
`else
  logic unused_wrap;
  assign unused_wrap = req_wrap;
`endif

  always_comb begin
    state_n     = state_q;
    cur_n       = cur_q;
    rem_n       = rem_q;
    req_ready_n = req_ready;
    ax_valid_n  = ax_valid;
    ax_addr_n   = ax_addr;
    ax_len_n    = ax_len;
    ax_burst_n  = ax_burst;
    ax_id_n     = ax_id;
    ax_write_n  = ax_write;
    busy_n      = busy;
    done_n      = 1'b0;
    beats       = 9'd0;

    end_addr    = AW1'(req_addr) + AW1'(req_bytes) - AW1'(1);
    total_beats = (end_addr >> SHIFT) - (AW1'(req_addr) >> SHIFT) + AW1'(1);
    aligned     = req_addr & ALIGN_MASK;
    issued      = 9'(ax_len) + 9'd1;
    cur_adv     = cur_q + (ADDR_WIDTH'(issued) << SHIFT);
    rem_left    = rem_q - RW'(issued);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ax_id_n     = req_id;
          ax_write_n  = req_write;
          req_ready_n = 1'b0;
          busy_n      = 1'b1;
          if (req_bytes == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
            rem_n   = '0;
          end else begin
            state_n    = ISSUE;
            ax_valid_n = 1'b1;
            cur_n      = aligned;
            rem_n      = RW'(total_beats);
            beats      = burst_beats(aligned[11:0], RW'(total_beats));
            ax_addr_n  = req_addr;
            ax_len_n   = 8'(beats - 9'd1);
            ax_burst_n = BURST_INCR;
`ifdef CACHE_WRAP_BURST_EN
            if (req_wrap && wrap_ok(req_bytes)) begin
              rem_n      = RW'(req_bytes >> SHIFT);
              ax_addr_n  = aligned;
              ax_len_n   = 8'((req_bytes >> SHIFT) - BYTE_CNT_WIDTH'(1));
              ax_burst_n = BURST_WRAP;
            end
`endif
          end
        end
      end
      ISSUE: begin
        if (ax_ready) begin
          cur_n = cur_adv;
          rem_n = rem_left;
          if (rem_left == '0) begin
            state_n    = DONE;
            ax_valid_n = 1'b0;
            done_n     = 1'b1;
          end else begin
            beats     = burst_beats(cur_adv[11:0], rem_left);
            ax_addr_n = cur_adv;
            ax_len_n  = 8'(beats - 9'd1);
          end
        end
      end
      DONE: begin
        state_n     = IDLE;
        req_ready_n = 1'b1;
        busy_n      = 1'b0;
      end
      default: begin
        state_n     = IDLE;
        req_ready_n = 1'b1;
        ax_valid_n  = 1'b0;
        busy_n      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      rem_q     <= '0;
      req_ready <= 1'b1;
      ax_valid  <= 1'b0;
      ax_addr   <= '0;
      ax_len    <= '0;
      ax_burst  <= '0;
      ax_id     <= '0;
      ax_write  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      cur_q     <= cur_n;
      rem_q     <= rem_n;
      req_ready <= req_ready_n;
      ax_valid  <= ax_valid_n;
      ax_addr   <= ax_addr_n;
      ax_len    <= ax_len_n;
      ax_burst  <= ax_burst_n;
      ax_id     <= ax_id_n;
      ax_write  <= ax_write_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_axi_burst_splitter.sv
// Self-checking bench for axi_burst_splitter: directed table, stall/reset sequences and randomized requests against a model.
module tb_axi_burst_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [15:0] req_bytes;
  logic [3:0]  req_id;
  logic        req_write, req_wrap;
  logic        ax_valid, ax_ready;
  logic [31:0] ax_addr;
  logic [7:0]  ax_len;
  logic [2:0]  ax_size;
  logic [1:0]  ax_burst;
  logic [3:0]  ax_id;
  logic        ax_write, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_burst_splitter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_bytes(req_bytes),
    .req_id(req_id), .req_write(req_write), .req_wrap(req_wrap),
    .ax_valid(ax_valid), .ax_ready(ax_ready), .ax_addr(ax_addr), .ax_len(ax_len),
    .ax_size(ax_size), .ax_burst(ax_burst), .ax_id(ax_id), .ax_write(ax_write),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [31:0]      addr;
    logic [15:0]      bytes;
    logic             wrap;
    logic [2:0]       n;
    logic [3:0][31:0] a;
    logic [3:0][7:0]  l;
    logic [3:0][1:0]  b;
  } vec_t;

  vec_t vecs[9];

  logic [31:0] ea_q[$];
  logic [7:0]  el_q[$];
  logic [1:0]  eb_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: walk the transfer beat-by-beat in plain arithmetic (B=4, cap 16, 4 KB pages).
  task automatic model(input logic [31:0] a, input logic [15:0] nb, input logic wp);
    longint unsigned la, beats, cur, room, n;
    bit first;
    if (nb == 0) return;
`ifdef CACHE_WRAP_BURST_EN
    if (wp && (nb == 8 || nb == 16 || nb == 32 || nb == 64)) begin
      ea_q.push_back(a & 32'hFFFF_FFFC);
      el_q.push_back(8'(nb / 4 - 1));
      eb_q.push_back(2'b10);
      return;
    end
`else
    if (wp) first = 1'b1;
`endif
    la    = a;
    beats = ((la + nb - 1) >> 2) - (la >> 2) + 1;
    cur   = la & ~64'h3;
    first = 1'b1;
    while (beats > 0) begin
      room = (4096 - (cur % 4096)) / 4;
      n = beats;
      if (n > 16) n = 16;
      if (n > room) n = room;
      ea_q.push_back(first ? a : 32'(cur));
      el_q.push_back(8'(n - 1));
      eb_q.push_back(2'b01);
      cur   = (cur + n * 4) % 64'h1_0000_0000;
      beats = beats - n;
      first = 1'b0;
    end
  endtask

  // mode 0: ax_ready always 1, 1: random ax_ready, 2: ax_ready low for cycles 2..6
  task automatic run_req(input logic [31:0] a, input logic [15:0] nb, input logic [3:0] id,
                         input logic wr, input logic wp, input int mode);
    int nexp, k, first_v, done_c;
    logic stalled;
    logic [31:0] pa;
    logic [7:0] pl;
    nexp = ea_q.size(); k = 0; first_v = -1; done_c = -1; stalled = 1'b0; pa = '0; pl = '0;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_bytes = nb; req_id = id; req_write = wr; req_wrap = wp;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      case (mode)
        1: ax_ready = 1'($urandom_range(0, 1));
        2: ax_ready = !(cyc >= 2 && cyc <= 6);
        default: ax_ready = 1'b1;
      endcase
      if (stalled) begin
        chk("stall_valid", ax_valid, 1);
        chk("stall_addr", ax_addr, pa);
        chk("stall_len", ax_len, pl);
      end
      if (done) begin
        done_c = cyc;
        chk("done_req_ready", req_ready, 0);
        chk("done_ax_valid", ax_valid, 0);
        break;
      end
      chk("busy_req_ready", req_ready, 0);
      chk("busy_flag", busy, 1);
      if (ax_valid && first_v < 0) first_v = cyc;
      if (ax_valid && ax_ready) begin
        if (k < nexp) begin
          chk($sformatf("addr_b%0d", k), ax_addr, ea_q[k]);
          chk($sformatf("len_b%0d", k), ax_len, el_q[k]);
          chk($sformatf("burst_b%0d", k), ax_burst, eb_q[k]);
          chk("ax_id", ax_id, id);
          chk("ax_write", ax_write, wr);
          chk("ax_size", ax_size, 3'd2);
        end
        k++;
      end
      stalled = ax_valid && !ax_ready;
      pa = ax_addr;
      pl = ax_len;
      @(negedge clk);
    end
    chk("done_seen", done_c > 0, 1);
    chk("burst_count", 64'(k), 64'(nexp));
    if (mode == 0) begin
      if (nexp > 0) chk("first_valid_cycle", 64'(first_v), 64'd1);
      chk("done_cycle", 64'(done_c), 64'(nexp + 1));
    end
    ax_ready = 1'b1;
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_busy", busy, 0);
    ea_q.delete(); el_q.delete(); eb_q.delete();
  endtask

  task automatic load_vec(input vec_t v);
    for (int j = 0; j < int'(v.n); j++) begin
      ea_q.push_back(v.a[j]);
      el_q.push_back(v.l[j]);
      eb_q.push_back(v.b[j]);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [15:0] rb;
    logic rw;
    logic [1:0] wrap_exp;
`ifdef CACHE_WRAP_BURST_EN
    wrap_exp = 2'b10;
`else
    wrap_exp = 2'b01;
`endif
    vecs[0] = '{addr: 32'h1000, bytes: 16'd64, wrap: 1'b0, n: 3'd1,
                a: {32'h0, 32'h0, 32'h0, 32'h1000}, l: {8'd0, 8'd0, 8'd0, 8'd15}, b: {2'd0, 2'd0, 2'd0, 2'b01}};
    vecs[1] = '{addr: 32'h0FF0, bytes: 16'd64, wrap: 1'b0, n: 3'd2,
                a: {32'h0, 32'h0, 32'h1000, 32'h0FF0}, l: {8'd0, 8'd0, 8'd11, 8'd3}, b: {2'd0, 2'd0, 2'b01, 2'b01}};
    vecs[2] = '{addr: 32'h2002, bytes: 16'd8, wrap: 1'b0, n: 3'd1,
                a: {32'h0, 32'h0, 32'h0, 32'h2002}, l: {8'd0, 8'd0, 8'd0, 8'd2}, b: {2'd0, 2'd0, 2'd0, 2'b01}};
    vecs[3] = '{addr: 32'h3000, bytes: 16'd200, wrap: 1'b0, n: 3'd4,
                a: {32'h30C0, 32'h3080, 32'h3040, 32'h3000}, l: {8'd1, 8'd15, 8'd15, 8'd15},
                b: {2'b01, 2'b01, 2'b01, 2'b01}};
    vecs[4] = '{addr: 32'h3000, bytes: 16'd0, wrap: 1'b0, n: 3'd0,
                a: '0, l: '0, b: '0};
    vecs[5] = '{addr: 32'h4008, bytes: 16'd32, wrap: 1'b1, n: 3'd1,
                a: {32'h0, 32'h0, 32'h0, 32'h4008}, l: {8'd0, 8'd0, 8'd0, 8'd7}, b: {2'd0, 2'd0, 2'd0, wrap_exp}};
    vecs[6] = '{addr: 32'h4008, bytes: 16'd24, wrap: 1'b1, n: 3'd1,
                a: {32'h0, 32'h0, 32'h0, 32'h4008}, l: {8'd0, 8'd0, 8'd0, 8'd5}, b: {2'd0, 2'd0, 2'd0, 2'b01}};
    vecs[7] = '{addr: 32'h1FFE, bytes: 16'd4, wrap: 1'b0, n: 3'd2,
                a: {32'h0, 32'h0, 32'h2000, 32'h1FFE}, l: {8'd0, 8'd0, 8'd0, 8'd0}, b: {2'd0, 2'd0, 2'b01, 2'b01}};
    vecs[8] = '{addr: 32'hFFFF_FFF8, bytes: 16'd16, wrap: 1'b0, n: 3'd2,
                a: {32'h0, 32'h0, 32'h0, 32'hFFFF_FFF8}, l: {8'd0, 8'd0, 8'd1, 8'd1}, b: {2'd0, 2'd0, 2'b01, 2'b01}};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_bytes = '0; req_id = '0;
    req_write = 1'b0; req_wrap = 1'b0; ax_ready = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_ax_valid", ax_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ax_addr", ax_addr, 0);
    chk("rst_ax_len", ax_len, 0);
    chk("rst_ax_burst", ax_burst, 0);
    chk("rst_ax_id", ax_id, 0);
    chk("rst_ax_write", ax_write, 0);
    chk("rst_ax_size", ax_size, 3'd2);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      load_vec(vecs[i]);
      run_req(vecs[i].addr, vecs[i].bytes, 4'(i + 3), 1'(i), vecs[i].wrap, 0);
    end

    // Stall mid-sequence: ax_* must hold while ax_ready is low.
    load_vec(vecs[3]);
    run_req(32'h3000, 16'd200, 4'hA, 1'b1, 1'b0, 2);

    // Reset while bursts are pending, then a clean restart.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h3000; req_bytes = 16'd200; req_id = 4'h5; req_write = 1'b1; req_wrap = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; ax_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", ax_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ax_valid", ax_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_ax_addr", ax_addr, 0);
    chk("mid_rst_ax_len", ax_len, 0);
    chk("mid_rst_ax_id", ax_id, 0);
    @(negedge clk);
    rst = 1'b0; ax_ready = 1'b1;
    load_vec(vecs[0]);
    run_req(32'h1000, 16'd64, 4'h2, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[11:8] = 4'hF;
      rb = 16'($urandom_range(0, 300));
      rw = 1'($urandom_range(0, 1));
      if (rw && $urandom_range(0, 1) == 1) rb = 16'(8 << $urandom_range(0, 3));
      model(ra, rb, rw);
      run_req(ra, rb, 4'($urandom), 1'($urandom), rw, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
